// File: rtl/multiplexer_4to1.sv
// Four-input data selector: combinational result on y, enable-gated registered
// copy on y_q, and a one-cycle pulse on sel_chg whenever the select value moves.
module multiplexer_4to1 #(
    parameter int unsigned      WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i0,
    input  logic [WIDTH-1:0] i1,
    input  logic [WIDTH-1:0] i2,
    input  logic [WIDTH-1:0] i3,
    input  logic             S0,
    input  logic             S1,
    input  logic             en,
    output logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] y_q,
    output logic             sel_chg
);

    logic [1:0]       sel;
    logic [1:0]       sel_prev;
    logic [WIDTH-1:0] y_next;

    assign sel = {S1, S0};

    // An unknown select matches no explicit item, so the default forces zeros
    // instead of letting X reach downstream logic.
    always_comb begin
        y_next = '0;
        case (sel)
            2'b00:   y_next = i0;
            2'b01:   y_next = i1;
            2'b10:   y_next = i2;
            2'b11:   y_next = i3;
            default: y_next = '0;
        endcase
    end

    assign y = y_next;

    // Select history is captured every edge, independent of the data enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_q      <= RESET_VAL;
            sel_prev <= 2'b00;
            sel_chg  <= 1'b0;
        end else begin
            if (en) begin
                y_q <= y_next;
            end
            sel_prev <= sel;
            sel_chg  <= (sel != sel_prev);
        end
    end

endmodule

// File: tb/tb_multiplexer_4to1.sv
// Self-checking bench for multiplexer_4to1: directed test-plan steps followed by
// randomized traffic compared against a behavioural reference model.
module tb_multiplexer_4to1;

    localparam int unsigned      W     = 4;
    localparam logic [W-1:0]     RVAL  = 4'hA;

    logic         clk;
    logic         rst_n;
    logic [W-1:0] i0, i1, i2, i3;
    logic         S0, S1, en;
    logic [W-1:0] y, y_q;
    logic         sel_chg;

    int n_checks = 0;
    int n_pass   = 0;

    multiplexer_4to1 #(.WIDTH(W), .RESET_VAL(RVAL)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .i0      (i0),
        .i1      (i1),
        .i2      (i2),
        .i3      (i3),
        .S0      (S0),
        .S1      (S1),
        .en      (en),
        .y       (y),
        .y_q     (y_q),
        .sel_chg (sel_chg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: pick the input whose index equals the select number.
    function automatic logic [W-1:0] pick(input logic [1:0] s);
        logic [W-1:0] d [4];
        d[0] = i0; d[1] = i1; d[2] = i2; d[3] = i3;
        return d[s];
    endfunction

    logic [W-1:0] m_yq;
    logic         m_chg;
    logic [1:0]   m_last_sel;

    // Model of the registered outputs, stated in terms of sampled selects.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_yq       = RVAL;
            m_chg      = 1'b0;
            m_last_sel = 2'd0;
        end else begin
            if (en) m_yq = pick({S1, S0});
            m_chg      = ({S1, S0} != m_last_sel);
            m_last_sel = {S1, S0};
        end
    end

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic check_comb(input string tag);
        check(tag, y, pick({S1, S0}));
    endtask

    task automatic check_regs(input string tag);
        check({tag, "_yq"}, y_q, m_yq);
        check({tag, "_chg"}, W'(sel_chg), W'(m_chg));
    endtask

    task automatic step_sel(input logic [1:0] s);
        @(negedge clk);
        {S1, S0} = s;
    endtask

    task automatic edge_check(input string tag);
        @(posedge clk);
        #1;
        check_regs(tag);
    endtask

    initial begin
        rst_n = 1'b1;
        {i0, i1, i2, i3} = '0;
        {S1, S0} = 2'b00;
        en = 1'b0;
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_yq", y_q, RVAL);
        check("rst_chg", W'(sel_chg), '0);
        check("y_all0", y, '0);
        i0 = 4'h1;
        #1 check("y_i0_noclk", y, 4'h1);

        @(negedge clk) rst_n = 1'b1;
        edge_check("rel_sel00");
        check("rel_no_chg", W'(sel_chg), '0);

        step_sel(2'b01);
        i1 = 4'h1;
        #1 check("y_sel01", y, 4'h1);
        i0 = 4'hF; #1 check("y_tog_i0", y, 4'h1);
        i2 = 4'hF; #1 check("y_tog_i2", y, 4'h1);
        i3 = 4'hF; #1 check("y_tog_i3", y, 4'h1);

        step_sel(2'b10);
        i2 = 4'h0; #1 check("y_sel10_0", y, 4'h0);
        i2 = 4'h1; #1 check("y_sel10_1", y, 4'h1);

        step_sel(2'b11);
        i3 = 4'h0; #1 check("y_sel11_0", y, 4'h0);
        i3 = 4'h1; #1 check("y_sel11_1", y, 4'h1);

        step_sel(2'b10);
        en = 1'b1;
        i2 = 4'h1;
        edge_check("reg_load");
        check("reg_load_1", y_q, 4'h1);
        @(negedge clk);
        en = 1'b0;
        i2 = 4'h0;
        edge_check("hold_a");
        edge_check("hold_b");
        check("hold_yq", y_q, 4'h1);
        check("hold_y", y, 4'h0);

        // Asynchronous reset between edges must act without a clock.
        #2 rst_n = 1'b0;
        #1;
        check("async_yq", y_q, RVAL);
        check("async_chg", W'(sel_chg), '0);
        check_comb("y_in_reset");
        step_sel(2'b00);
        rst_n = 1'b1;
        edge_check("rel2");
        step_sel(2'b11);
        edge_check("chg_pulse");
        check("chg_pulse_1", W'(sel_chg), 4'h1);
        edge_check("chg_end");
        check("chg_end_0", W'(sel_chg), '0);

        // Randomized traffic, including occasional mid-cycle resets.
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            rst_n = 1'b1;
            i0 = W'($urandom);
            i1 = W'($urandom);
            i2 = W'($urandom);
            i3 = W'($urandom);
            en = 1'($urandom);
            if ($urandom_range(0, 1) == 0) {S1, S0} = 2'($urandom);
            #1 check_comb("rnd_y");
            @(posedge clk);
            #1 check_regs("rnd");
            if ($urandom_range(0, 19) == 0) begin
                #2 rst_n = 1'b0;
                #1 check_regs("rnd_rst");
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/multiplexer_4to1.md
# multiplexer_4to1

Four-input, one-output selector with a combinational output path and an optional registered copy of the same result. Two select bits (`S1` MSB, `S0` LSB) pick one of four data inputs `i0`..`i3`. It serves as a generic data-steering leaf cell. The combinational output `y` feeds same-cycle logic; the registered output `y_q` feeds timing-critical paths.

## Interface
- Clocking: one clock; reset is asynchronous and active-low (`clk`, `rst_n`).
- Parameters:
  - `WIDTH`, default 1: bit width of each data input and of `y` / `y_q`.
  - `RESET_VAL`, default 0: value loaded into `y_q` on reset.
- Ports:
  - `clk`  input  1: rising-edge clock for the registered path.
  - `rst_n`  input  1: asynchronous active-low reset.
  - `i0`  input  WIDTH: data, selected when {S1,S0}=00.
  - `i1`  input  WIDTH: data, selected when {S1,S0}=01.
  - `i2`  input  WIDTH: data, selected when {S1,S0}=10.
  - `i3`  input  WIDTH: data, selected when {S1,S0}=11.
  - `S0`  input  1: select LSB.
  - `S1`  input  1: select MSB.
  - `en`  input  1: load enable for `y_q`.
  - `y`  output  WIDTH: combinational mux result.
  - `y_q`  output  WIDTH: registered mux result.
  - `sel_chg`  output  1: registered one-cycle pulse when the select value differs from the previous cycle's.

## Operation
- `y` = `i0` / `i1` / `i2` / `i3` for {S1,S0} = 00 / 01 / 10 / 11.
- `y` is purely combinational and independent of `clk`, `rst_n` and `en`.
- `y` responds to any change on the selected input or on either select bit.
- Changes on unselected inputs have no effect on `y`.
- If any select bit is X or Z, `y` is all zeros. There is no X-propagation.
- Registered path:
  - On each rising `clk` with `en`=1, `y_q` <= the current `y`.
  - With `en`=0, `y_q` holds its value.
- Select tracking:
  - An internal register `sel_prev` captures {S1,S0} every rising `clk`, regardless of `en`.
  - `sel_chg` <= ({S1,S0} != `sel_prev`).
- Reset (`rst_n`=0, asynchronous):
  - `y_q` = `RESET_VAL`.
  - `sel_prev` = 2'b00.
  - `sel_chg` = 0.
  - These values are held for as long as `rst_n` is low.
  - `y` continues to follow its inputs during reset.
- Reset deasserts synchronously to `clk` at the system level. The first capture happens on the first rising edge after `rst_n` goes high.

## Timing
- `y` has zero-cycle latency: combinational delay only.
- `y_q` has one-cycle latency: it reflects the inputs sampled at the rising edge where `en`=1.
- `sel_chg` has one-cycle latency.
  - A select change between edges N-1 and N makes `sel_chg`=1 for exactly the cycle after edge N.
  - This holds only if {S1,S0} stays stable afterward.
- Simultaneous data and select change before an edge: `y_q` captures the new input under the new select.
- Reset asserted mid-operation: `y_q` and `sel_chg` clear immediately, with no wait for `clk`.
- Reset release: no spurious `sel_chg` on the first edge if {S1,S0}=00. Otherwise `sel_chg`=1 for one cycle.

## Test plan
- All inputs 0, select 00 -> `y`=0. Then `i0`=1 with select 00 -> `y`=1 with no clock required.
- Select 01, `i1`=1 -> `y`=1. Toggle `i0`, `i2`, `i3` -> `y` stays 1.
- Select 10:
  - `i2`=0 -> `y`=0.
  - Then `i2`=1 -> `y`=1.
- Select 11:
  - `i3`=0 -> `y`=0.
  - Then `i3`=1 -> `y`=1.
- Registered path:
  - `en`=1, select 10, `i2`=1, one rising edge -> `y_q`=1.
  - `en`=0, `i2`=0, two edges -> `y_q` stays 1, while `y`=0.
- Reset and select tracking:
  - Assert `rst_n`=0 between edges -> `y_q`=`RESET_VAL` and `sel_chg`=0 immediately.
  - Release, then change select 00->11 -> `sel_chg`=1 for exactly one cycle after the next edge.
